// File: rtl/rib_gpio_ctrl.sv
// GPIO controller on the peripheral RIB port: synchronised and debounced inputs,
// atomic set/clear/toggle output updates and per-pin edge interrupts.
module rib_gpio_ctrl #(
    parameter int NPIN        = 24,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 16,
    parameter int ADDR_W      = 6
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [31:0]     i_ribs_addr,
    input  logic            i_ribs_wrcs,
    input  logic [3:0]      i_ribs_mask,
    input  logic [31:0]     i_ribs_wdata,
    output logic [31:0]     o_ribs_rdata,
    input  logic            i_ribs_req,
    output logic            o_ribs_gnt,
    output logic            o_ribs_rsp,
    input  logic            i_ribs_rdy,
    input  logic [NPIN-1:0] i_gpio_in,
    output logic [NPIN-1:0] o_gpio_out,
    output logic [NPIN-1:0] o_gpio_mode,
    output logic            o_irq
);
    typedef enum logic {S_IDLE, S_RESP} state_t;

    localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_OUT  = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_SET  = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_CLR  = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_TGL  = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] A_IN   = ADDR_W'(32'h14);
    localparam logic [ADDR_W-1:0] A_RISE = ADDR_W'(32'h18);
    localparam logic [ADDR_W-1:0] A_FALL = ADDR_W'(32'h1C);
    localparam logic [ADDR_W-1:0] A_PEND = ADDR_W'(32'h20);
    localparam logic [ADDR_W-1:0] A_DIV  = ADDR_W'(32'h24);

    state_t                           r_state;
    logic [31:0]                      r_rdata;
    logic [NPIN-1:0]                  r_mode, r_out, r_rise_en, r_fall_en, r_pend;
    logic [NPIN-1:0]                  r_smp, r_filt, r_filt_d;
    logic [SYNC_STAGES-1:0][NPIN-1:0] r_sync;
    logic [DEB_W-1:0]                 r_deb_div, r_deb_cnt;
    logic                             r_irq;

    logic              w_gnt, w_wr, w_tick, w_unused;
    logic              w_wr_mode, w_wr_out, w_wr_set, w_wr_clr, w_wr_tgl;
    logic              w_wr_rise, w_wr_fall, w_wr_pend, w_wr_div;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_bmask, w_rdata;
    logic [NPIN-1:0]   w_pmask, w_wbits, w_s, w_agree, w_set, w_clr_pend;
    logic [DEB_W-1:0]  w_div_next;

    assign w_gnt   = (r_state == S_IDLE) && i_ribs_req;
    assign w_wr    = w_gnt && i_ribs_wrcs;
    assign w_addr  = {i_ribs_addr[ADDR_W-1:2], 2'b00};
    assign w_bmask = {{8{i_ribs_mask[3]}}, {8{i_ribs_mask[2]}},
                      {8{i_ribs_mask[1]}}, {8{i_ribs_mask[0]}}};
    assign w_pmask = w_bmask[NPIN-1:0];
    assign w_wbits = i_ribs_wdata[NPIN-1:0] & w_pmask;
    assign w_div_next = (r_deb_div & ~w_bmask[DEB_W-1:0])
                      | (i_ribs_wdata[DEB_W-1:0] & w_bmask[DEB_W-1:0]);
    assign w_unused = ^{i_ribs_addr, i_ribs_wdata, w_bmask};

    assign w_wr_mode = w_wr && (w_addr == A_MODE);
    assign w_wr_out  = w_wr && (w_addr == A_OUT);
    assign w_wr_set  = w_wr && (w_addr == A_SET);
    assign w_wr_clr  = w_wr && (w_addr == A_CLR);
    assign w_wr_tgl  = w_wr && (w_addr == A_TGL);
    assign w_wr_rise = w_wr && (w_addr == A_RISE);
    assign w_wr_fall = w_wr && (w_addr == A_FALL);
    assign w_wr_pend = w_wr && (w_addr == A_PEND);
    assign w_wr_div  = w_wr && (w_addr == A_DIV);

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_agree    = ~(w_s ^ r_smp);
    assign w_tick     = (r_deb_cnt == '0);
    assign w_set      = (r_filt & ~r_filt_d & r_rise_en) | (~r_filt & r_filt_d & r_fall_en);
    assign w_clr_pend = w_wr_pend ? w_wbits : '0;

    always_comb begin
        // NOTE: default first so every path assigns w_rdata and no latch is inferred.
        w_rdata = '0;
        case (w_addr)
            A_MODE:  w_rdata = 32'(r_mode);
            A_OUT:   w_rdata = 32'(r_out);
            A_IN:    w_rdata = 32'(r_filt);
            A_RISE:  w_rdata = 32'(r_rise_en);
            A_FALL:  w_rdata = 32'(r_fall_en);
            A_PEND:  w_rdata = 32'(r_pend);
            A_DIV:   w_rdata = 32'(r_deb_div);
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: reset is sampled on the clock edge, and non-blocking assignments let
        // every flop below see pre-edge values regardless of statement order.
        if (i_rst) begin
            r_mode    <= '0;
            r_out     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_pend    <= '0;
            r_deb_div <= '0;
            r_deb_cnt <= '0;
            r_sync    <= '0;
            r_smp     <= '0;
            r_filt    <= '0;
            r_filt_d  <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr_mode) r_mode    <= (r_mode & ~w_pmask) | w_wbits;
            if (w_wr_rise) r_rise_en <= (r_rise_en & ~w_pmask) | w_wbits;
            if (w_wr_fall) r_fall_en <= (r_fall_en & ~w_pmask) | w_wbits;
            if (w_wr_div)  r_deb_div <= w_div_next;

            if (w_wr_out)      r_out <= (r_out & ~w_pmask) | w_wbits;
            else if (w_wr_set) r_out <= r_out | w_wbits;
            else if (w_wr_clr) r_out <= r_out & ~w_wbits;
            else if (w_wr_tgl) r_out <= r_out ^ w_wbits;

            // A new event outranks a simultaneous W1C of the same bit.
            r_pend <= (r_pend & ~w_clr_pend) | w_set;
            r_irq  <= |r_pend;

            if (w_wr_div)    r_deb_cnt <= w_div_next;
            else if (w_tick) r_deb_cnt <= r_deb_div;
            else             r_deb_cnt <= r_deb_cnt - DEB_W'(1);

            r_sync[0] <= i_gpio_in;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];

            if (r_deb_div == '0) begin
                r_filt <= w_s;
            end else if (w_tick) begin
                r_smp  <= w_s;
                r_filt <= (r_filt & ~w_agree) | (w_s & w_agree);
            end
            r_filt_d <= r_filt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_ribs_req) begin
                    r_rdata <= i_ribs_wrcs ? '0 : w_rdata;
                    r_state <= S_RESP;
                end
                S_RESP: if (i_ribs_rdy) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ribs_gnt   = w_gnt;
    assign o_ribs_rsp   = (r_state == S_RESP);
    assign o_ribs_rdata = r_rdata;
    assign o_gpio_out   = r_out;
    assign o_gpio_mode  = r_mode;
    assign o_irq        = r_irq;
endmodule

// File: tb/tb_rib_gpio_ctrl.sv
// Scoreboard bench for rib_gpio_ctrl: the driver queues expected read data,
// a monitor pops and compares on every response handshake.
module tb_rib_gpio_ctrl;
    localparam int NPIN = 24;
    localparam int SYNC = 2;
    localparam logic [31:0] A_MODE = 32'h00, A_OUT = 32'h04, A_SET = 32'h08, A_CLR = 32'h0C;
    localparam logic [31:0] A_TGL = 32'h10, A_IN = 32'h14, A_RISE = 32'h18, A_FALL = 32'h1C;
    localparam logic [31:0] A_PEND = 32'h20, A_DIV = 32'h24;

    typedef struct {
        logic        is_rd;
        logic [31:0] exp;
        string       nm;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_fail = 0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     addr = '0;
    logic            wrcs = 1'b0;
    logic [3:0]      mask = 4'hF;
    logic [31:0]     wdata = '0;
    logic [31:0]     rdata;
    logic            req = 1'b0;
    logic            gnt;
    logic            rsp;
    logic            rdy = 1'b1;
    logic [NPIN-1:0] gpio_in = '0;
    logic [NPIN-1:0] gpio_out;
    logic [NPIN-1:0] gpio_mode;
    logic            irq;

    rib_gpio_ctrl #(.NPIN(NPIN), .SYNC_STAGES(SYNC), .DEB_W(16), .ADDR_W(6)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ribs_addr(addr), .i_ribs_wrcs(wrcs), .i_ribs_mask(mask),
        .i_ribs_wdata(wdata), .o_ribs_rdata(rdata),
        .i_ribs_req(req), .o_ribs_gnt(gnt), .o_ribs_rsp(rsp), .i_ribs_rdy(rdy),
        .i_gpio_in(gpio_in), .o_gpio_out(gpio_out), .o_gpio_mode(gpio_mode), .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full access with rdy high; called just after a rising edge.
    task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [31:0] exp, input string nm);
        sb_t e;
        bit  got;
        e.is_rd = !wr;
        e.exp   = exp;
        e.nm    = nm;
        req = 1'b1; wrcs = wr; addr = a; wdata = d; mask = m;
        sb_q.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL gnt_timeout %s: no grant within 20 cycles", nm);
            void'(sb_q.pop_back());
            req = 1'b0;
            wait_cyc(1);
        end else begin
            @(posedge clk); #1;
            req = 1'b0; wrcs = 1'b0;
            @(negedge clk);
            check({nm, "_rsp_after_gnt"}, 32'(rsp), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        bus(1'b0, a, 32'h0, 4'hF, exp, nm);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
        bus(1'b1, a, d, 4'hF, 32'h0, nm);
    endtask

    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp && rdy) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: response with empty scoreboard, rdata 0x%08h", rdata);
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_rd) check(e.nm, rdata, e.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset state
        wait_cyc(3);
        @(negedge clk);
        check("rst_rsp", 32'(rsp), 32'd0);
        check("rst_gpio_out", 32'(gpio_out), 32'd0);
        check("rst_gpio_mode", 32'(gpio_mode), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cyc(1);
        for (int a = 0; a <= 32'h28; a += 4) rd(32'(a), 32'h0, $sformatf("rst_rd_%02h", a));
        @(negedge clk);
        check("rst_irq_after_reads", 32'(irq), 32'd0);
        @(posedge clk); #1;

        // Output register and atomic updates
        wr(A_MODE, 32'hF, "wr_mode");
        check("gpio_mode_f", 32'(gpio_mode), 32'hF);
        wr(A_OUT, 32'h5, "wr_out");
        check("out_5", 32'(gpio_out), 32'h5);
        wr(A_SET, 32'h2, "wr_set");
        check("out_set_7", 32'(gpio_out), 32'h7);
        wr(A_CLR, 32'h1, "wr_clr");
        check("out_clr_6", 32'(gpio_out), 32'h6);
        wr(A_TGL, 32'h8, "wr_tgl");
        check("out_tgl_e", 32'(gpio_out), 32'hE);
        rd(A_SET, 32'h0, "rd_set_zero");
        rd(A_OUT, 32'hE, "rd_out_e");
        bus(1'b1, A_OUT, 32'hFFFF_FFFF, 4'b0001, 32'h0, "wr_out_byte0");
        check("out_byte0_ff", 32'(gpio_out), 32'hFF);
        bus(1'b1, A_SET, 32'hFFFF_FFFF, 4'b0010, 32'h0, "wr_set_byte1");
        check("out_set_byte1", 32'(gpio_out), 32'hFFFF);
        wr(A_MODE, 32'hFFFF_FFFF, "wr_mode_all");
        rd(A_MODE, 32'h00FF_FFFF, "rd_mode_npin");
        rd(32'h40, 32'h00FF_FFFF, "rd_mode_alias");
        wr(32'h28, 32'hFFFF_FFFF, "wr_unmapped");
        rd(32'h28, 32'h0, "rd_unmapped");
        rd(A_MODE, 32'h00FF_FFFF, "rd_mode_kept");

        // Bypass edge interrupt latency and W1C
        wr(A_RISE, 32'h8, "wr_rise3");
        gpio_in[3] = 1'b1;
        repeat (SYNC + 2) @(posedge clk);
        @(negedge clk);
        check("irq_not_yet", 32'(irq), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("irq_latency", 32'(irq), 32'd1);
        @(posedge clk); #1;
        rd(A_PEND, 32'h8, "rd_pend_rise");
        wr(A_PEND, 32'h8, "wr_pend_w1c");
        wait_cyc(1);
        check("irq_cleared", 32'(irq), 32'd0);
        rd(A_PEND, 32'h0, "rd_pend_cleared");
        gpio_in[3] = 1'b0;
        wait_cyc(10);
        rd(A_PEND, 32'h0, "rd_pend_fall_ignored");
        check("irq_fall_ignored", 32'(irq), 32'd0);

        // Debounce with DEB_DIV = 9
        wr(A_DIV, 32'h9, "wr_div9");
        wr(A_RISE, 32'h9, "wr_rise30");
        rd(A_DIV, 32'h9, "rd_div9");
        gpio_in[0] = 1'b1;
        wait_cyc(5);
        gpio_in[0] = 1'b0;
        wait_cyc(40);
        rd(A_IN, 32'h0, "rd_in_glitch");
        rd(A_PEND, 32'h0, "rd_pend_glitch");
        gpio_in[0] = 1'b1;
        wait_cyc(SYNC + 21);
        rd(A_IN, 32'h1, "rd_in_step");
        wait_cyc(13);
        gpio_in[0] = 1'b0;
        rd(A_PEND, 32'h1, "rd_pend_step");
        wait_cyc(30);
        rd(A_IN, 32'h0, "rd_in_step_low");
        wr(A_PEND, 32'h1, "wr_pend_clr0");
        wr(A_DIV, 32'h0, "wr_div0");
        rd(A_PEND, 32'h0, "rd_pend_after_deb");

        // Response stall with rdy low
        wr(A_MODE, 32'hA5, "wr_mode_a5");
        req = 1'b1; wrcs = 1'b0; addr = A_MODE; mask = 4'hF; rdy = 1'b0;
        sb_q.push_back('{1'b1, 32'hA5, "rd_mode_stalled"});
        @(negedge clk);
        check("stall_gnt_first", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_rsp_%0d", k), 32'(rsp), 32'd1);
            check($sformatf("stall_rdata_%0d", k), rdata, 32'hA5);
            check($sformatf("stall_gnt_%0d", k), 32'(gnt), 32'd0);
            @(posedge clk); #1;
        end
        rdy = 1'b1;
        addr = A_RISE;
        sb_q.push_back('{1'b1, 32'h9, "rd_rise_after_stall"});
        @(negedge clk);
        check("gnt_in_rdy_cycle", 32'(gnt), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("gnt_after_rdy", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("rsp_after_stall_gnt", 32'(rsp), 32'd1);
        @(posedge clk); #1;

        // Edge and W1C on the same bit in the same cycle: set wins
        gpio_in[3] = 1'b1;
        wait_cyc(SYNC + 1);
        wr(A_PEND, 32'h8, "wr_pend_collide");
        rd(A_PEND, 32'h8, "rd_pend_set_wins");
        check("irq_set_wins", 32'(irq), 32'd1);

        // Reset in the middle of a response
        gpio_in = '0;
        wait_cyc(4);
        req = 1'b1; wrcs = 1'b0; addr = A_MODE; rdy = 1'b0;
        sb_q.push_back('{1'b1, 32'hA5, "rd_mode_aborted"});
        @(negedge clk);
        check("abort_gnt", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("abort_rsp_before", 32'(rsp), 32'd1);
        check("abort_irq_before", 32'(irq), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_rsp", 32'(rsp), 32'd0);
        check("abort_rdata", rdata, 32'h0);
        check("abort_gpio_out", 32'(gpio_out), 32'd0);
        check("abort_gpio_mode", 32'(gpio_mode), 32'd0);
        check("abort_irq", 32'(irq), 32'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; rdy = 1'b1;
        wait_cyc(1);
        rd(A_MODE, 32'h0, "post_rst_mode");
        rd(A_OUT, 32'h0, "post_rst_out");
        rd(A_RISE, 32'h0, "post_rst_rise");
        rd(A_FALL, 32'h0, "post_rst_fall");
        rd(A_PEND, 32'h0, "post_rst_pend");
        rd(A_DIV, 32'h0, "post_rst_div");
        rd(A_IN, 32'h0, "post_rst_in");

        wait_cyc(2);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
